ras_ckpt: RTL and testbench

Parametrised speculative return address stack for the fetch stage, with in-order branch checkpoints. Fetch pushes on calls and pops on returns speculatively. Each predicted branch takes a checkpoint. On a mispredict, decode/issue restores the stack top pointer, top entry and occupancy to the checkpointed values in one cycle. Replaces the fixed 32-bit, non-recoverable RAS.

---
 rtl/ras_ckpt.sv | 132 +++++++++++++
 tb/tb_ras_ckpt.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ras_ckpt.sv
// Speculative return address stack with in-order branch checkpoints.
// A mispredict rolls back tos, the top entry and occupancy in one cycle.
module ras_ckpt #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned CKPT_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [ADDR_W-1:0]             new_addr,
    output logic [ADDR_W-1:0]             addr,
    output logic                          valid,
    output logic [$clog2(DEPTH):0]        count,
    input  logic                          ckpt_req,
    output logic [$clog2(CKPT_DEPTH)-1:0] ckpt_id,
    output logic                          ckpt_full,
    input  logic                          ckpt_release,
    input  logic                          restore,
    input  logic [$clog2(CKPT_DEPTH)-1:0] restore_id
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(CKPT_DEPTH);

    logic [ADDR_W-1:0] ram_q [DEPTH];
    logic [PW-1:0]     tos_q, tos_d;
    logic [PW:0]       cnt_q, cnt_d;

    logic [PW-1:0]     ck_tos_q  [CKPT_DEPTH];
    logic [ADDR_W-1:0] ck_addr_q [CKPT_DEPTH];
    logic [PW:0]       ck_cnt_q  [CKPT_DEPTH];
    logic [CW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW:0]       live_q, live_d;

    logic              wr_en;
    logic [PW-1:0]     wr_idx;
    logic [ADDR_W-1:0] wr_data;
    logic              alloc, rel, full;

    assign full      = (live_q == (CW+1)'(CKPT_DEPTH));
    assign valid     = (cnt_q != '0);
    assign addr      = valid ? ram_q[tos_q] : '0;
    assign count     = cnt_q;
    assign ckpt_id   = tail_q;
    assign ckpt_full = full;

    always_comb begin
        tos_d   = tos_q;
        cnt_d   = cnt_q;
        head_d  = head_q;
        tail_d  = tail_q;
        live_d  = live_q;
        wr_en   = 1'b0;
        wr_idx  = tos_q;
        wr_data = new_addr;
        rel     = ckpt_release && (live_q != '0);
        alloc   = 1'b0;

        if (restore) begin
            tos_d   = ck_tos_q[restore_id];
            cnt_d   = ck_cnt_q[restore_id];
            wr_en   = 1'b1;
            wr_idx  = ck_tos_q[restore_id];
            wr_data = ck_addr_q[restore_id];
            head_d  = rel ? head_q + CW'(1) : head_q;
            // Releasing the very checkpoint being restored empties the FIFO past it.
            if (rel && (restore_id == head_q)) begin
                tail_d = head_q + CW'(1);
                live_d = '0;
            end else begin
                tail_d = restore_id;
                live_d = {1'b0, restore_id - head_d};
            end
        end else begin
            case ({push, pop})
                2'b10: begin
                    tos_d  = tos_q + PW'(1);
                    wr_en  = 1'b1;
                    wr_idx = tos_q + PW'(1);
                    if (cnt_q != (PW+1)'(DEPTH)) cnt_d = cnt_q + (PW+1)'(1);
                end
                2'b01: begin
                    if (cnt_q != '0) begin
                        tos_d = tos_q - PW'(1);
                        cnt_d = cnt_q - (PW+1)'(1);
                    end
                end
                2'b11: begin
                    wr_en  = 1'b1;
                    wr_idx = tos_q;
                    if (cnt_q == '0) cnt_d = (PW+1)'(1);
                end
                default: ;
            endcase

            alloc  = ckpt_req && !full;
            head_d = rel ? head_q + CW'(1) : head_q;
            tail_d = alloc ? tail_q + CW'(1) : tail_q;
            if (alloc && !rel)      live_d = live_q + (CW+1)'(1);
            else if (rel && !alloc) live_d = live_q - (CW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tos_q  <= '0;
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            live_q <= '0;
        end else begin
            tos_q  <= tos_d;
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
            live_q <= live_d;
        end
    end

    // Storage is never cleared; stale contents stay hidden behind valid.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) ram_q[wr_idx] <= wr_data;
        if (!rst && alloc) begin
            ck_tos_q[tail_q]  <= tos_q;
            ck_addr_q[tail_q] <= ram_q[tos_q];
            ck_cnt_q[tail_q]  <= cnt_q;
        end
    end

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed-vector bench for ras_ckpt (DEPTH=8, CKPT_DEPTH=4).
module tb_ras_ckpt;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0, pop = 1'b0;
    logic [31:0] new_addr = '0;
    logic [31:0] addr;
    logic        valid;
    logic [3:0]  count;
    logic        ckpt_req = 1'b0;
    logic [1:0]  ckpt_id;
    logic        ckpt_full;
    logic        ckpt_release = 1'b0;
    logic        restore = 1'b0;
    logic [1:0]  restore_id = '0;

    int checks = 0;
    int errors = 0;

    logic [1:0] m_head = '0;
    int         m_live = 0;

    ras_ckpt #(.ADDR_W(32), .DEPTH(8), .CKPT_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .new_addr(new_addr),
        .addr(addr), .valid(valid), .count(count), .ckpt_req(ckpt_req),
        .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
        .restore(restore), .restore_id(restore_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic        rst, push, pop;
        logic [31:0] na;
        logic        req, rel, rs;
        logic [1:0]  rid;
        logic [31:0] e_addr;
        logic [3:0]  e_cnt;
        logic [1:0]  e_id;
        logic        e_full;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t op(int tag, bit r, bit pu, bit po, logic [31:0] na,
                                bit rq, bit rl, bit rs, logic [1:0] rid,
                                logic [31:0] ea, int ec, int eid, bit ef);
        vec_t v;
        v.tag = tag; v.rst = r; v.push = pu; v.pop = po; v.na = na;
        v.req = rq; v.rel = rl; v.rs = rs; v.rid = rid;
        v.e_addr = ea; v.e_cnt = 4'(ec); v.e_id = 2'(eid); v.e_full = ef;
        return v;
    endfunction

    task automatic chk(input string nm, input int tag, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s scen %0d vec %0d: got %0h expected %0h", nm, tag, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input int idx);
        logic [1:0] d;
        @(negedge clk);
        rst = v.rst; push = v.push; pop = v.pop; new_addr = v.na;
        ckpt_req = v.req; ckpt_release = v.rel; restore = v.rs; restore_id = v.rid;
        if (v.rs && !v.rst) begin
            d = v.rid - m_head;
            assert (int'(d) < m_live) else $error("bench drove restore of non-live id %0d", v.rid);
        end
        @(posedge clk);
        #1;
        if (v.rst) begin
            m_head = '0; m_live = 0;
        end else if (v.rs) begin
            if (v.rel && m_live > 0 && v.rid == m_head) begin
                m_head = m_head + 2'd1; m_live = 0;
            end else begin
                if (v.rel && m_live > 0) m_head = m_head + 2'd1;
                d = v.rid - m_head;
                m_live = int'(d);
            end
        end else begin
            if (v.rel && m_live > 0) begin m_head = m_head + 2'd1; m_live--; end
            if (v.req && m_live < 4) m_live++;
        end
        chk("addr",  v.tag, idx, addr,            v.e_addr);
        chk("valid", v.tag, idx, 32'(valid),      32'(v.e_cnt != 0));
        chk("count", v.tag, idx, 32'(count),      32'(v.e_cnt));
        chk("ckpt_id", v.tag, idx, 32'(ckpt_id),  32'(v.e_id));
        chk("ckpt_full", v.tag, idx, 32'(ckpt_full), 32'(v.e_full));
    endtask

    initial begin
        // Basic push/pop and underflow.
        vecs.push_back(op(1, 1,0,0, 0,       0,0,0,0, 0,       0,0,0));
        vecs.push_back(op(1, 0,1,0, 'h100,   0,0,0,0, 'h100,   1,0,0));
        vecs.push_back(op(1, 0,1,0, 'h200,   0,0,0,0, 'h200,   2,0,0));
        vecs.push_back(op(1, 0,1,0, 'h300,   0,0,0,0, 'h300,   3,0,0));
        vecs.push_back(op(1, 0,0,1, 0,       0,0,0,0, 'h200,   2,0,0));
        vecs.push_back(op(1, 0,0,1, 0,       0,0,0,0, 'h100,   1,0,0));
        vecs.push_back(op(1, 0,0,1, 0,       0,0,0,0, 0,       0,0,0));
        vecs.push_back(op(1, 0,0,1, 0,       0,0,0,0, 0,       0,0,0));

        // Overflow: 9th push lands on slot 1, replacing 0x10, so after seven
        // pops (0x80..0x20) the eighth empties the stack instead of exposing 0x10.
        vecs.push_back(op(2, 1,0,0, 0, 0,0,0,0, 0, 0,0,0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(op(2, 0,1,0, 32'(i*'h10), 0,0,0,0, 32'(i*'h10), (i > 8) ? 8 : i, 0,0));
        for (int j = 1; j <= 7; j++)
            vecs.push_back(op(2, 0,0,1, 0, 0,0,0,0, 32'('h90 - j*'h10), 8-j, 0,0));
        vecs.push_back(op(2, 0,0,1, 0, 0,0,0,0, 0, 0,0,0));
        vecs.push_back(op(2, 0,0,1, 0, 0,0,0,0, 0, 0,0,0));

        // Checkpoint then speculative ops, restore.
        vecs.push_back(op(3, 1,0,0, 0,     0,0,0,0, 0,     0,0,0));
        vecs.push_back(op(3, 0,1,0, 'hA0,  0,0,0,0, 'hA0,  1,0,0));
        vecs.push_back(op(3, 0,0,0, 0,     1,0,0,0, 'hA0,  1,1,0));
        vecs.push_back(op(3, 0,1,0, 'hB0,  0,0,0,0, 'hB0,  2,1,0));
        vecs.push_back(op(3, 0,0,1, 0,     0,0,0,0, 'hA0,  1,1,0));
        vecs.push_back(op(3, 0,1,0, 'hC0,  0,0,0,0, 'hC0,  2,1,0));
        vecs.push_back(op(3, 0,0,0, 0,     0,0,1,0, 'hA0,  1,0,0));

        // Checkpoint FIFO full / ignored request / release / wrap.
        vecs.push_back(op(4, 1,0,0, 0, 0,0,0,0, 0, 0,0,0));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,1,0));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,2,0));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,3,0));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,0,1));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,0,1));
        vecs.push_back(op(4, 0,0,0, 0, 0,1,0,0, 0, 0,0,0));
        vecs.push_back(op(4, 0,0,0, 0, 1,0,0,0, 0, 0,1,1));

        // Same-cycle combinations.
        vecs.push_back(op(5, 1,0,0, 0,    0,0,0,0, 0,    0,0,0));
        vecs.push_back(op(5, 0,1,1, 'h44, 0,0,0,0, 'h44, 1,0,0));
        vecs.push_back(op(5, 0,1,0, 'h55, 1,0,0,0, 'h55, 2,1,0));
        vecs.push_back(op(5, 0,1,0, 'h66, 0,0,0,0, 'h66, 3,1,0));
        vecs.push_back(op(5, 0,1,0, 'h77, 0,0,1,0, 'h44, 1,0,0));
        vecs.push_back(op(5, 0,1,0, 'h88, 0,0,0,0, 'h88, 2,0,0));
        vecs.push_back(op(5, 0,0,1, 0,    0,0,0,0, 'h44, 1,0,0));

        // Reset mid-operation wins over push and ckpt_req.
        vecs.push_back(op(6, 0,1,0, 'h12, 1,0,0,0, 'h12, 2,1,0));
        vecs.push_back(op(6, 1,1,0, 'h99, 1,0,0,0, 0,    0,0,0));

        for (int k = 0; k < vecs.size(); k++) drive(vecs[k], k);

        // Restore id 1 with checkpoints 0,1,2 live and a same-cycle release.
        drive(op(7, 1,0,0, 0,    0,0,0,0, 0,    0,0,0), 0);
        drive(op(7, 0,1,0, 'h1A, 0,0,0,0, 'h1A, 1,0,0), 1);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h1A, 1,1,0), 2);
        drive(op(7, 0,1,0, 'h2B, 0,0,0,0, 'h2B, 2,1,0), 3);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h2B, 2,2,0), 4);
        drive(op(7, 0,1,0, 'h3C, 0,0,0,0, 'h3C, 3,2,0), 5);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h3C, 3,3,0), 6);
        drive(op(7, 0,1,0, 'h4D, 0,0,0,0, 'h4D, 4,3,0), 7);
        drive(op(7, 0,0,0, 0,    0,1,1,1, 'h2B, 2,1,0), 8);
        drive(op(7, 0,0,1, 0,    0,0,0,0, 'h1A, 1,1,0), 9);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h1A, 1,2,0), 10);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h1A, 1,3,0), 11);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h1A, 1,0,0), 12);
        drive(op(7, 0,0,0, 0,    1,0,0,0, 'h1A, 1,1,1), 13);

        // Restore of the head checkpoint with release: FIFO empties past it.
        drive(op(8, 1,0,0, 0,    0,0,0,0, 0,    0,0,0), 0);
        drive(op(8, 0,1,0, 'h11, 0,0,0,0, 'h11, 1,0,0), 1);
        drive(op(8, 0,0,0, 0,    1,0,0,0, 'h11, 1,1,0), 2);
        drive(op(8, 0,1,0, 'h22, 0,0,0,0, 'h22, 2,1,0), 3);
        drive(op(8, 0,0,0, 0,    0,1,1,0, 'h11, 1,1,0), 4);
        drive(op(8, 0,0,0, 0,    0,1,0,0, 'h11, 1,1,0), 5);
        drive(op(8, 0,0,0, 0,    1,0,0,0, 'h11, 1,2,0), 6);
        drive(op(8, 0,0,0, 0,    1,0,0,0, 'h11, 1,3,0), 7);
        drive(op(8, 0,0,0, 0,    1,0,0,0, 'h11, 1,0,0), 8);
        drive(op(8, 0,0,0, 0,    1,0,0,0, 'h11, 1,1,1), 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
